load_store_unit: RTL and testbench

//  CPU-side initiator for the byte-addressed data memory port (addr/wen/wdata/rdata).

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory port bundle for load_store_unit.
// slave: the LSU view (takes requests, drives the memory port).
// master: the requester/memory side (execute stage plus data memory).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    // request from execute stage
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    // completion
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    // data memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wen, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wen, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a byte-addressed data memory, with load
// extension and read-modify-write for sub-word stores. Latency: load/word store 2, sub-word store 3, error 1.
// Backpressure: one request at a time, req_ready only when idle; requests while busy are not queued.
// Ports: clock, reset (async active-high), bus (load_store_unit_if.slave: req_*, resp_*, mem_*).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests complete with resp_err=1, no memory access.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t            state, state_n;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;     // store data, later the merged sub-word write word
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_misaligned;
    logic [31:0]       rd_word;    // read word normalised to {b3,b2,b1,b0}
    logic [31:0]       load_ext;
    logic [31:0]       merged;
    logic              sub_word;

    assign accept = (state == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                            (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    // memory returns byte A+k in the top-down lane k; swap so b0 sits at [7:0]
    assign rd_word = {bus.mem_rdata[7:0], bus.mem_rdata[15:8],
                      bus.mem_rdata[23:16], bus.mem_rdata[31:24]};

    // size 3 is reserved and behaves as a word, so size_q[1] means "full word"
    assign sub_word = !size_q[1];

    always_comb begin
        load_ext = rd_word;
        merged   = rd_word;
        case (size_q)
            2'd0: begin
                load_ext = {{24{!uns_q && rd_word[7]}}, rd_word[7:0]};
                merged   = {rd_word[31:8], data_q[7:0]};
            end
            2'd1: begin
                load_ext = {{16{!uns_q && rd_word[15]}}, rd_word[15:0]};
                merged   = {rd_word[31:16], data_q[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        addr_q  <= bus.req_addr;
                        data_q  <= bus.req_wdata;
                        rdata_q <= 32'd0;
                        err_q   <= req_misaligned;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_ext;
                    end else if (sub_word) begin
                        data_q <= merged;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = req_misaligned ? RESP : ACCESS;
            ACCESS:  state_n = (we_q && sub_word) ? WRITE : RESP;
            WRITE:   state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // mem_wen is decoded from the state register so reset removes it without waiting for an edge
    assign bus.mem_wen    = ((state == ACCESS) && we_q && !sub_word) || (state == WRITE);
    assign bus.mem_wdata  = bus.mem_wen ? data_q : 32'd0;
    assign bus.mem_addr   = addr_q;
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.resp_err   = err_q;
`else
    assign bus.resp_err   = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b1;

    always #5 clock = ~clock;

    load_store_unit_if #(.ADDR_W(32)) bus ();
    load_store_unit #(.ADDR_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    // 256-byte data memory; byte A+k returned on the top-down lane k, written from lane 8k
    logic [7:0] mem [256];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h14] <= 8'h5A;
            mem[8'h30] <= 8'h77;
        end else if (bus.mem_wen) begin
            for (int k = 0; k < 4; k++) mem[8'(bus.mem_addr[7:0] + k)] <= bus.mem_wdata[8*k +: 8];
        end
    end
    always_comb begin
        logic [7:0] a;
        a = bus.mem_addr[7:0];
        bus.mem_rdata = {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wen;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rd, logic err, int lat, int wen);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_wen = wen;
        return v;
    endfunction

    task automatic do_req(input vec_t v, input int idx);
        int lat;
        int wen;
        @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        check("ready_before_accept", idx, 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        wen = 0;
        forever begin
            @(negedge clock);
            lat++;
            if (bus.mem_wen) wen++;
            if (bus.resp_valid) break;
            if (lat > 20) break;
        end
        check("resp_latency", idx, 32'(lat), 32'(v.exp_lat));
        check("resp_rdata", idx, bus.resp_rdata, v.exp_rdata);
        check("resp_err", idx, 32'(bus.resp_err), 32'(v.exp_err));
        check("mem_wen_cycles", idx, 32'(wen), 32'(v.exp_wen));
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_req_ready", 0, 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 0, 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 0, 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", 0, bus.resp_rdata, 32'd0);
        check("rst_mem_addr", 0, bus.mem_addr, 32'd0);
        check("rst_mem_wen", 0, 32'(bus.mem_wen), 32'd0);
        check("rst_mem_wdata", 0, bus.mem_wdata, 32'd0);
        preload = 1'b0;
        reset = 1'b0;

        //                we    sz    uns   addr      wdata         rdata         err lat wen
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h00000000, 1'b0, 2, 1));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11223344, 1'b0, 2, 0));
        tbl.push_back(mk(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFAB, 32'h00000000, 1'b0, 3, 1));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1122AB44, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h14, 32'h0,        32'h0000005A, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h12, 32'h0,        32'h00000022, 1'b0, 2, 0));
        tbl.push_back(mk(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 32'h00000000, 1'b0, 3, 1));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF8022, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h00008022, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h8022AB44, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000044, 1'b0, 2, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234BEEF, 32'h00000000, 1'b1, 1, 0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 32'h21, 32'h0,        32'h00000000, 1'b1, 1, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        32'h00000000, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h22, 32'h0,        32'h00000000, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h00000000, 1'b1, 1, 0));
`else
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234BEEF, 32'h00000000, 1'b0, 3, 1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 32'h21, 32'h0,        32'h0000BEEF, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        32'h000000EF, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h22, 32'h0,        32'h000000BE, 1'b0, 2, 0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h5A8022AB, 1'b0, 2, 0));
`endif
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        32'h00000000, 1'b0, 2, 0));

        for (int i = 0; i < tbl.size(); i++) do_req(tbl[i], i);

        // reset during the WRITE cycle of a byte store must suppress the write
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h30; bus.req_wdata = 32'h000000CD;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);                 // read cycle
        check("rmw_read_wen", 100, 32'(bus.mem_wen), 32'd0);
        check("rmw_read_addr", 100, bus.mem_addr, 32'h30);
        @(negedge clock);                 // write cycle
        check("rmw_write_wen", 100, 32'(bus.mem_wen), 32'd1);
        check("rmw_write_wdata", 100, bus.mem_wdata, 32'h000000CD);
        reset = 1'b1;
        #1;
        check("mid_rst_mem_wen", 100, 32'(bus.mem_wen), 32'd0);
        check("mid_rst_req_ready", 100, 32'(bus.req_ready), 32'd1);
        check("mid_rst_resp_valid", 100, 32'(bus.resp_valid), 32'd0);
        check("mid_rst_mem_addr", 100, bus.mem_addr, 32'd0);
        check("mid_rst_mem_wdata", 100, bus.mem_wdata, 32'd0);
        check("mid_rst_resp_rdata", 100, bus.resp_rdata, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_byte_kept", 100, 32'(mem[8'h30]), 32'h77);
        do_req(mk(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h00000077, 1'b0, 2, 0), 101);

        // request held valid: one accept per IDLE visit, next accept right after resp_valid
        begin
            int accepts, first_resp, second_acc, c;
            accepts = 0; first_resp = -1; second_acc = -1;
            @(negedge clock);
            bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
            bus.req_unsigned = 1'b0; bus.req_addr = 32'h10;
            for (c = 0; c < 6; c++) begin
                if (c > 0) @(negedge clock);
                if (bus.resp_valid && first_resp < 0) first_resp = c;
                if (bus.req_ready && bus.req_valid) begin
                    accepts++;
                    if (accepts == 2) second_acc = c;
                end
                if (c == 5) bus.req_valid = 1'b0;
            end
            check("held_accepts", 102, 32'(accepts), 32'd2);
            check("held_first_resp", 102, 32'(first_resp), 32'd2);
            check("held_second_accept", 102, 32'(second_acc), 32'd3);
            @(negedge clock);
            check("held_final_idle", 102, 32'(bus.req_ready), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
